// File: rtl/gettoniera_pkg.sv
// Shared types and constants for the coin-acceptor front end.
package gettoniera_pkg;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    IDLE    = 2'd1,
    CONFIRM = 2'd2,
    HELD    = 2'd3
  } ch_state_e;

  localparam int unsigned DEF_DEB_CYCLES  = 4;
  localparam int unsigned DEF_LOCK_CYCLES = 8;
  localparam int unsigned DEF_CNT_W       = 8;

  // Bits needed to hold a counter that reaches max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned DEF_DEB_W  = cnt_width(DEF_DEB_CYCLES);
  localparam int unsigned DEF_LOCK_W = cnt_width(DEF_LOCK_CYCLES);

endpackage

// File: rtl/gettoniera_coin_debounce.sv
// One coin channel: 2-flop synchroniser, arm/confirm/held debounce FSM, one-cycle rise event.
module coin_debounce
  import gettoniera_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic rise_o
);

  localparam int unsigned DW = cnt_width(DEB_CYCLES);
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_CYCLES);

  logic          sync1_q, sync2_q;
  ch_state_e     state_q, state_d;
  logic [DW-1:0] deb_q, deb_d, deb_inc;
  logic          rise_q, rise_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ARM;
      deb_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
    end
  end

  assign deb_inc = deb_q + DW'(1);

  // ARM needs a clean low run before the channel may fire again.
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    rise_d  = 1'b0;
    case (state_q)
      ARM: begin
        if (sync2_q) begin
          deb_d = '0;
        end else if (deb_inc == DEB_MAX) begin
          state_d = IDLE;
          deb_d   = '0;
        end else begin
          deb_d = deb_inc;
        end
      end
      IDLE: begin
        if (sync2_q) begin
          state_d = CONFIRM;
          deb_d   = DW'(1);
        end
      end
      CONFIRM: begin
        if (!sync2_q) begin
          state_d = IDLE;
          deb_d   = '0;
        end else if (deb_inc == DEB_MAX) begin
          state_d = HELD;
          deb_d   = '0;
          rise_d  = 1'b1;
        end else begin
          deb_d = deb_inc;
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = ARM;
          deb_d   = DW'(1);
        end
      end
      default: begin
        state_d = ARM;
        deb_d   = '0;
      end
    endcase
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/gettoniera.sv
// Coin-acceptor front end: per-channel debounce, arbitration with lockout, saturating coin count.
module gettoniera
  import gettoniera_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coin_d_raw,
  input  logic             coin_v_raw,
  output logic             d_o,
  output logic             v_o,
  output logic             reject_o,
  output logic [CNT_W-1:0] coin_cnt_o
);

  localparam int unsigned LW = cnt_width(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             d_rise, v_rise;
  logic [LW-1:0]    lock_q, lock_d;
  logic             d_pulse_q, d_pulse_d;
  logic             v_pulse_q, v_pulse_d;
  logic             rej_q, rej_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_d (
    .clk    (clk),
    .rst_n  (reset),
    .raw_i  (coin_d_raw),
    .rise_o (d_rise)
  );

  coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_v (
    .clk    (clk),
    .rst_n  (reset),
    .raw_i  (coin_v_raw),
    .rise_o (v_rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q    <= '0;
      d_pulse_q <= 1'b0;
      v_pulse_q <= 1'b0;
      rej_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      lock_q    <= lock_d;
      d_pulse_q <= d_pulse_d;
      v_pulse_q <= v_pulse_d;
      rej_q     <= rej_d;
      cnt_q     <= cnt_d;
    end
  end

  // Rejections during lockout do not extend the window; only a fresh decision reloads it.
  always_comb begin
    d_pulse_d = 1'b0;
    v_pulse_d = 1'b0;
    rej_d     = 1'b0;
    cnt_d     = cnt_q;
    lock_d    = (lock_q != '0) ? lock_q - LW'(1) : '0;
    if (d_rise || v_rise) begin
      if (lock_q != '0) begin
        rej_d = 1'b1;
      end else if (d_rise && v_rise) begin
        rej_d  = 1'b1;
        lock_d = LW'(LOCK_CYCLES);
      end else begin
        d_pulse_d = d_rise;
        v_pulse_d = v_rise;
        lock_d    = LW'(LOCK_CYCLES);
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign d_o        = d_pulse_q;
  assign v_o        = v_pulse_q;
  assign reject_o   = rej_q;
  assign coin_cnt_o = cnt_q;

endmodule

// File: tb/tb_gettoniera.sv
// Self-checking bench: run-length reference model of the coin front end, directed scenarios plus random stimulus.
module tb_gettoniera;

  localparam int DEB  = 4;
  localparam int LOCK = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       raw_d = 1'b0;
  logic       raw_v = 1'b0;
  logic       d_o, v_o, rej_o;
  logic [7:0] cnt_o;
  logic       d2_o, v2_o, rej2_o;
  logic [1:0] cnt2_o;

  always #5 clk = ~clk;

  gettoniera #(.DEB_CYCLES(DEB), .LOCK_CYCLES(LOCK), .CNT_W(8)) dut (
    .clk(clk), .reset(rst_n), .coin_d_raw(raw_d), .coin_v_raw(raw_v),
    .d_o(d_o), .v_o(v_o), .reject_o(rej_o), .coin_cnt_o(cnt_o)
  );

  gettoniera #(.DEB_CYCLES(DEB), .LOCK_CYCLES(LOCK), .CNT_W(2)) dut2 (
    .clk(clk), .reset(rst_n), .coin_d_raw(raw_d), .coin_v_raw(raw_v),
    .d_o(d2_o), .v_o(v2_o), .reject_o(rej2_o), .coin_cnt_o(cnt2_o)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sync delay line, per-channel high/low run lengths, time-based lockout window.
  int m_cyc, m_last, m_acc;
  bit m_have;
  bit e_d, e_v, e_r;
  bit ms1[2], ms2[2], pend[2], armed[2];
  int hi[2], lo[2];
  bit samp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_last = 0; m_acc = 0; m_have = 0;
      e_d = 0; e_v = 0; e_r = 0;
      for (int c = 0; c < 2; c++) begin
        ms1[c] = 0; ms2[c] = 0; pend[c] = 0; armed[c] = 0; hi[c] = 0; lo[c] = 0;
      end
    end else begin
      e_d = 0; e_v = 0; e_r = 0;
      if (pend[0] || pend[1]) begin
        if (m_have && (m_cyc - m_last) <= LOCK) begin
          e_r = 1;
        end else begin
          m_have = 1;
          m_last = m_cyc;
          if (pend[0] && pend[1]) e_r = 1;
          else begin
            e_d = pend[0];
            e_v = pend[1];
            m_acc++;
          end
        end
      end
      for (int c = 0; c < 2; c++) begin
        samp   = ms2[c];
        ms2[c] = ms1[c];
        ms1[c] = (c == 0) ? raw_d : raw_v;
        pend[c] = 0;
        if (samp) begin
          lo[c] = 0;
          hi[c]++;
          if (armed[c] && hi[c] == DEB) begin
            pend[c]  = 1;
            armed[c] = 0;
          end
        end else begin
          hi[c] = 0;
          lo[c]++;
          if (lo[c] >= DEB) armed[c] = 1;
        end
      end
      m_cyc++;
    end
  end

  int n_d = 0, n_v = 0, n_r = 0;

  always @(negedge clk) begin
    chk("d_o", d_o, e_d);
    chk("v_o", v_o, e_v);
    chk("reject_o", rej_o, e_r);
    chk("coin_cnt_o", cnt_o, (m_acc > 255) ? 255 : m_acc);
    chk("d_o_w2", d2_o, e_d);
    chk("v_o_w2", v2_o, e_v);
    chk("reject_o_w2", rej2_o, e_r);
    chk("coin_cnt_o_w2", cnt2_o, (m_acc > 3) ? 3 : m_acc);
    if (d_o) n_d++;
    if (v_o) n_v++;
    if (rej_o) n_r++;
  end

  int bd, bv, br;

  task automatic snap();
    bd = n_d; bv = n_v; br = n_r;
  endtask

  task automatic deltas(input string tag, input int dd, input int dv, input int dr);
    chk({tag, "_nd"}, n_d - bd, dd);
    chk({tag, "_nv"}, n_v - bv, dv);
    chk({tag, "_nrej"}, n_r - br, dr);
  endtask

  // Drive each raw line high for cycles [start, start+len) of a total-cycle window.
  task automatic drive(input int ds, input int dl, input int vs, input int vl, input int total);
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      #1;
      raw_d = (c >= ds) && (c < ds + dl);
      raw_v = (c >= vs) && (c < vs + vl);
    end
  endtask

  task automatic do_reset(input bit hold_d);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    raw_d = hold_d;
    raw_v = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int lat;
  int exp_sat[6];
  int seg[2];
  bit lvl[2];

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_d_o", d_o, 0);
    chk("rst_v_o", v_o, 0);
    chk("rst_reject_o", rej_o, 0);
    chk("rst_cnt", cnt_o, 0);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 6);

    // Clean D coin with latency measurement.
    snap();
    @(negedge clk);
    #1;
    raw_d = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (d_o && lat == 0) lat = k;
    end
    #1;
    raw_d = 1'b0;
    drive(0, 0, 0, 0, 10);
    chk("clean_latency", lat, 7);
    deltas("clean", 1, 0, 0);
    chk("clean_cnt", cnt_o, 1);

    // Bouncing V line never confirms.
    snap();
    drive(0, 0, 0, 2, 2);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 2, 2);
    drive(0, 0, 0, 0, 20);
    deltas("bounce", 0, 0, 0);
    chk("bounce_cnt", cnt_o, 1);

    // Simultaneous D and V.
    snap();
    drive(0, 10, 0, 10, 30);
    deltas("collide", 0, 0, 1);
    chk("collide_cnt", cnt_o, 1);

    // V inside lockout, then V outside lockout.
    snap();
    drive(0, 10, 5, 10, 40);
    deltas("lock_in", 1, 0, 1);
    chk("lock_in_cnt", cnt_o, 2);
    snap();
    drive(0, 10, 12, 10, 45);
    deltas("lock_out", 1, 1, 0);
    chk("lock_out_cnt", cnt_o, 4);

    // D held through reset release, then released for 4 cycles and reinserted.
    snap();
    do_reset(1'b1);
    drive(0, 30, 0, 0, 30);
    deltas("held", 0, 0, 0);
    drive(4, 10, 0, 0, 30);
    deltas("rearm", 1, 0, 0);
    chk("rearm_cnt", cnt_o, 1);

    // Saturation of the narrow counter.
    exp_sat[0] = 1; exp_sat[1] = 2; exp_sat[2] = 3;
    exp_sat[3] = 3; exp_sat[4] = 3; exp_sat[5] = 3;
    do_reset(1'b0);
    drive(0, 0, 0, 0, 6);
    snap();
    for (int i = 0; i < 6; i++) begin
      drive(0, 10, 0, 0, 30);
      chk("sat_cnt2", cnt2_o, exp_sat[i]);
      chk("sat_cnt8", cnt_o, i + 1);
      chk("sat_nd", n_d - bd, i + 1);
    end

    // Random segments on both lines, with occasional short resets.
    seg[0] = 0; seg[1] = 0; lvl[0] = 0; lvl[1] = 0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      #1;
      for (int c = 0; c < 2; c++) begin
        if (seg[c] == 0) begin
          lvl[c] = ~lvl[c];
          seg[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 16));
        end
        seg[c]--;
      end
      raw_d = lvl[0];
      raw_v = lvl[1];
      rst_n = ($urandom_range(0, 999) != 0);
    end
    #1;
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
